// File: rtl/press_judge_multi.sv
// Multi-channel button press classifier: glitch / short / long press with a per-channel toggle latch.
// Optional auto-repeat pulses while a long press is held: define PRESS_JUDGE_REPEAT_EN.
module press_judge_multi #(
    parameter int            CH          = 5,
    parameter int            DEB_CYC     = 2_000_000,
    parameter int            LONG_CYC    = 100_000_000,
    parameter int            REPEAT_CYC  = 25_000_000,
    parameter logic [CH-1:0] TOGGLE_INIT = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] btn_i,
    input  logic          clr_i,
    output logic [CH-1:0] short_o,
    output logic [CH-1:0] long_o,
    output logic [CH-1:0] held_o,
    output logic [CH-1:0] toggle_o,
    output logic [CH-1:0] rpt_o
);

    localparam int            CW     = $clog2(LONG_CYC + 1);
    localparam logic [CW-1:0] DEB_V  = CW'(DEB_CYC);
    localparam logic [CW-1:0] LONG_V = CW'(LONG_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PRESSED = 2'd2,
        ST_LONG    = 2'd3
    } state_t;

    if ((DEB_CYC < 1) || (DEB_CYC >= LONG_CYC) || (REPEAT_CYC < 1)) begin : g_bad_params
        $error("press_judge_multi: illegal DEB_CYC/LONG_CYC/REPEAT_CYC");
    end

    logic [CH-1:0] sync1_q;
    logic [CH-1:0] s_q;

    // Two-flop synchroniser for the raw asynchronous button inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {CH{1'b0}};
            s_q     <= {CH{1'b0}};
        end else begin
            sync1_q <= btn_i;
            s_q     <= sync1_q;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          short_q, short_d;
        logic          long_q, long_d;
        logic          held_q, held_d;
        logic          toggle_q, toggle_d;
        logic          s;

        assign s = s_q[g];

        // State and press-length counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= {CW{1'b0}};
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state logic; the counter holds at LONG_CYC once in LONG
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        cnt_d = CW'(1);
                        if (DEB_CYC == 1) begin
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (s) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d >= DEB_V) begin
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (s) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_d >= LONG_V) begin
                            state_d = ST_LONG;
                        end else begin
                            state_d = ST_PRESSED;
                        end
                    end else begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                    end
                end
                ST_LONG: begin
                    if (s) begin
                        cnt_d   = LONG_V;
                        state_d = ST_LONG;
                    end else begin
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Output decode; held_q is still 0 only in the first LONG cycle, which marks entry
        always_comb begin
            short_d = (state_q == ST_PRESSED) && !s;
            long_d  = (state_q == ST_LONG) && !held_q;
            held_d  = (state_q == ST_LONG) && s;
            if (clr_i) begin
                toggle_d = TOGGLE_INIT[g];
            end else if (long_d) begin
                toggle_d = !toggle_q;
            end else begin
                toggle_d = toggle_q;
            end
        end

        // Registered outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                short_q  <= 1'b0;
                long_q   <= 1'b0;
                held_q   <= 1'b0;
                toggle_q <= TOGGLE_INIT[g];
            end else begin
                short_q  <= short_d;
                long_q   <= long_d;
                held_q   <= held_d;
                toggle_q <= toggle_d;
            end
        end

        assign short_o[g]  = short_q;
        assign long_o[g]   = long_q;
        assign held_o[g]   = held_q;
        assign toggle_o[g] = toggle_q;

`ifdef PRESS_JUDGE_REPEAT_EN
        localparam int            RW       = $clog2(REPEAT_CYC + 1);
        localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);

        logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
        logic          rpt_q, rpt_d;

        // Repeat timer: held at 0 in the long_o cycle so the first pulse lands REPEAT_CYC later
        always_comb begin
            rpt_cnt_d = {RW{1'b0}};
            rpt_d     = 1'b0;
            if ((state_q == ST_LONG) && s && held_q) begin
                if (rpt_cnt_q == RPT_LAST) begin
                    rpt_cnt_d = {RW{1'b0}};
                    rpt_d     = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + RW'(1);
                    rpt_d     = 1'b0;
                end
            end else begin
                rpt_cnt_d = {RW{1'b0}};
                rpt_d     = 1'b0;
            end
        end

        // Repeat timer and pulse register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt_cnt_q <= {RW{1'b0}};
                rpt_q     <= 1'b0;
            end else begin
                rpt_cnt_q <= rpt_cnt_d;
                rpt_q     <= rpt_d;
            end
        end

        assign rpt_o[g] = rpt_q;
`else
        assign rpt_o[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_press_judge_multi.sv
// Directed self-checking bench for press_judge_multi (CH=2, DEB=4, LONG=20, REPEAT=8).
module tb_press_judge_multi;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_i;
    logic       clr_i;
    logic [1:0] short_o, long_o, held_o, toggle_o, rpt_o;

    press_judge_multi #(
        .CH(2), .DEB_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8), .TOGGLE_INIT(2'b00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_i), .clr_i(clr_i),
        .short_o(short_o), .long_o(long_o), .held_o(held_o),
        .toggle_o(toggle_o), .rpt_o(rpt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_short [2] = '{0, 0};
    int n_long  [2] = '{0, 0};
    int n_held  [2] = '{0, 0};
    int n_rpt   [2] = '{0, 0};
    int last_short_cyc [2] = '{0, 0};
    int last_long_cyc  [2] = '{0, 0};
    int last_held_cyc  [2] = '{0, 0};
    int rpt_log0 [$];

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (short_o[c]) begin
                n_short[c] <= n_short[c] + 1;
                last_short_cyc[c] <= cyc;
            end
            if (long_o[c]) begin
                n_long[c] <= n_long[c] + 1;
                last_long_cyc[c] <= cyc;
            end
            if (held_o[c]) begin
                n_held[c] <= n_held[c] + 1;
                last_held_cyc[c] <= cyc;
            end
            if (rpt_o[c]) n_rpt[c] <= n_rpt[c] + 1;
        end
        if (rpt_o[0]) rpt_log0.push_back(cyc);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int e, r;
    int s_short[2], s_long[2], s_held[2], s_rpt[2];

    task automatic snap();
        for (int c = 0; c < 2; c++) begin
            s_short[c] = n_short[c];
            s_long[c]  = n_long[c];
            s_held[c]  = n_held[c];
            s_rpt[c]   = n_rpt[c];
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_i = 2'b00;
        clr_i = 1'b0;
        tick(3);
        check("rst_short",  int'(short_o),  0);
        check("rst_long",   int'(long_o),   0);
        check("rst_held",   int'(held_o),   0);
        check("rst_toggle", int'(toggle_o), 0);
        check("rst_rpt",    int'(rpt_o),    0);
        rst_n = 1'b1;
        tick(3);

        // Glitch: 3 high cycles, below debounce
        snap();
        btn_i[0] = 1'b1; tick(3); btn_i[0] = 1'b0; tick(10);
        check("glitch_short", n_short[0] - s_short[0], 0);
        check("glitch_long",  n_long[0]  - s_long[0],  0);
        check("glitch_held",  n_held[0]  - s_held[0],  0);

        // Short press: 10 high cycles
        snap();
        btn_i[0] = 1'b1; e = cyc; tick(10); btn_i[0] = 1'b0; tick(10);
        check("short_cnt",  n_short[0] - s_short[0], 1);
        check("short_time", last_short_cyc[0], e + 13);
        check("short_long", n_long[0] - s_long[0], 0);

        // Long press on channel 1, twice
        for (int k = 0; k < 2; k++) begin
            snap();
            btn_i[1] = 1'b1; e = cyc; tick(30); btn_i[1] = 1'b0; tick(10);
            check("long_cnt",    n_long[1] - s_long[1], 1);
            check("long_time",   last_long_cyc[1], e + 23);
            check("held_end",    last_held_cyc[1], e + 32);
            check("held_len",    n_held[1] - s_held[1], 10);
            check("long_noshrt", n_short[1] - s_short[1], 0);
            check("long_ch0",    n_long[0] - s_long[0], 0);
            check("long_toggle", int'(toggle_o), (k == 0) ? 2 : 0);
        end

        // Both channels long, clear coincident with the long entry
        snap();
        btn_i = 2'b11; e = cyc; tick(22);
        clr_i = 1'b1; tick(1);
        check("clr_long_both", int'(long_o),   3);
        check("clr_toggle",    int'(toggle_o), 0);
        check("clr_held_both", int'(held_o),   3);
        tick(1); clr_i = 1'b0; tick(8);
        btn_i = 2'b00; tick(10);
        check("clr_long0",   n_long[0] - s_long[0], 1);
        check("clr_long1",   n_long[1] - s_long[1], 1);
        check("clr_toggle2", int'(toggle_o), 0);

        // Reset mid-press with the button still held
        snap();
        btn_i[0] = 1'b1; tick(15);
        rst_n = 1'b0; #1;
        check("midrst_out", int'({short_o, long_o, held_o, toggle_o}), 0);
        tick(2);
        check("midrst_out2", int'({short_o, long_o, held_o, toggle_o}), 0);
        check("midrst_nolong", n_long[0] - s_long[0], 0);
        rst_n = 1'b1; r = cyc; tick(30);
        check("rel_long_cnt",  n_long[0] - s_long[0], 1);
        check("rel_long_time", last_long_cyc[0], r + 23);
        check("rel_toggle",    int'(toggle_o), 1);
        btn_i[0] = 1'b0; tick(10);

        // Long hold for 50 cycles: auto-repeat behaviour
        snap();
        rpt_log0.delete();
        btn_i[0] = 1'b1; e = cyc; tick(50); btn_i[0] = 1'b0; tick(15);
        check("hold50_long",   last_long_cyc[0], e + 23);
        check("hold50_toggle", int'(toggle_o), 0);
`ifdef PRESS_JUDGE_REPEAT_EN
        check("rpt_cnt", n_rpt[0] - s_rpt[0], 3);
        for (int k = 0; k < rpt_log0.size() && k < 3; k++)
            check("rpt_time", rpt_log0[k], e + 23 + 8 * (k + 1));
`else
        check("rpt_cnt",   n_rpt[0] - s_rpt[0], 0);
        check("rpt_total", n_rpt[0] + n_rpt[1], 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
